// File: rtl/sp_ram_arb_pkg.sv
// Shared types for the two-master single-port RAM front end.
// Request/response bundles and master identifiers.
package sp_ram_arb_pkg;

  localparam int unsigned MEM_AW = 32;
  localparam int unsigned MEM_DW = 32;
  localparam int unsigned MEM_BW = MEM_DW / 8;

  typedef enum logic [0:0] {
    PORT_M0 = 1'b0,
    PORT_M1 = 1'b1
  } port_id_e;

  typedef struct packed {
    logic [MEM_AW-1:0] addr;
    logic              we;
    logic [MEM_BW-1:0] be;
    logic [MEM_DW-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic              rvalid;
    logic [MEM_DW-1:0] rdata;
    logic              err;
  } mem_rsp_t;

  function automatic port_id_e other_port(input port_id_e p);
    return (p == PORT_M0) ? PORT_M1 : PORT_M0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with combinational grant.
// Priority pointer moves to the loser after every grant.
module rr_arb2
  import sp_ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rstn_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  port_id_e r_prio;
  port_id_e w_prio_nxt;

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0] && (!req_i[1] || r_prio == PORT_M0)) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end
  end

  always_comb begin
    w_prio_nxt = r_prio;
    if (gnt_o[0]) begin
      w_prio_nxt = other_port(PORT_M0);
    end else if (gnt_o[1]) begin
      w_prio_nxt = other_port(PORT_M1);
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_prio <= PORT_M0;
    end else begin
      r_prio <= w_prio_nxt;
    end
  end

endmodule

// File: rtl/sp_ram_port_arb.sv
// Two-master req/gnt/rvalid front end for a 1-cycle-latency single-port RAM.
// Round-robin grant, range check and one-cycle response return.
module sp_ram_port_arb
  import sp_ram_arb_pkg::*;
#(
  parameter int unsigned RAM_SIZE   = 32768,
  parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int unsigned DATA_WIDTH = MEM_DW
) (
  input  logic                    clk,
  input  logic                    rstn_i,

  input  logic                    m0_req_i,
  input  logic [31:0]             m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_gnt_o,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  output logic                    m0_err_o,

  input  logic                    m1_req_i,
  input  logic [31:0]             m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_gnt_o,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    m1_err_o,

  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  mem_req_t   w_req [2];
  mem_rsp_t   w_rsp [2];
  logic [1:0] w_gnt;
  mem_req_t   w_win;
  port_id_e   w_win_id;
  logic       w_any;
  logic       w_oor;
  logic       w_en;

  logic       r_rsp_valid;
  port_id_e   r_rsp_id;
  logic       r_rsp_err;

  assign w_req[0] = '{
    addr:  m0_addr_i,
    we:    m0_we_i,
    be:    m0_be_i,
    wdata: m0_wdata_i
  };
  assign w_req[1] = '{
    addr:  m1_addr_i,
    we:    m1_we_i,
    be:    m1_be_i,
    wdata: m1_wdata_i
  };

  rr_arb2 u_arb (
    .clk    (clk),
    .rstn_i (rstn_i),
    .req_i  ({m1_req_i, m0_req_i}),
    .gnt_o  (w_gnt)
  );

  assign m0_gnt_o = w_gnt[0];
  assign m1_gnt_o = w_gnt[1];

  always_comb begin
    w_win    = '0;
    w_win_id = PORT_M0;
    unique case (1'b1)
      w_gnt[0]: begin
        w_win    = w_req[0];
        w_win_id = PORT_M0;
      end
      w_gnt[1]: begin
        w_win    = w_req[1];
        w_win_id = PORT_M1;
      end
      default: ;
    endcase
  end

  assign w_any = |w_gnt;
  assign w_oor = |w_win.addr[31:ADDR_WIDTH];
  assign w_en  = w_any & ~w_oor;

  // Out-of-range accesses never touch the RAM; all ram_* stay quiet.
  assign ram_en_o    = w_en;
  assign ram_we_o    = w_en & w_win.we;
  assign ram_addr_o  = w_en ? w_win.addr[ADDR_WIDTH-1:0] : '0;
  assign ram_be_o    = w_en ? w_win.be : '0;
  assign ram_wdata_o = w_en ? w_win.wdata : '0;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= PORT_M0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_any;
      r_rsp_id    <= w_win_id;
      r_rsp_err   <= w_any & w_oor;
    end
  end

  // Read data passes straight from the RAM; the RAM already holds it a cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_rsp[i].rvalid = r_rsp_valid & (r_rsp_id == port_id_e'(i));
      w_rsp[i].err    = w_rsp[i].rvalid & r_rsp_err;
      w_rsp[i].rdata  = (w_rsp[i].rvalid & ~r_rsp_err) ? ram_rdata_i : '0;
    end
  end

  assign m0_rvalid_o = w_rsp[0].rvalid;
  assign m0_rdata_o  = w_rsp[0].rdata;
  assign m0_err_o    = w_rsp[0].err;
  assign m1_rvalid_o = w_rsp[1].rvalid;
  assign m1_rdata_o  = w_rsp[1].rdata;
  assign m1_err_o    = w_rsp[1].err;

endmodule

// File: tb/tb_sp_ram_port_arb.sv
// Directed bench for sp_ram_port_arb with a behavioural 1-cycle RAM.
// Inputs change on negedge; outputs are sampled away from posedge.
module tb_sp_ram_port_arb;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        m0_req_i, m1_req_i;
  logic [31:0] m0_addr_i, m1_addr_i;
  logic        m0_we_i, m1_we_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic [31:0] m0_wdata_i, m1_wdata_i;
  logic        m0_gnt_o, m1_gnt_o;
  logic        m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        m0_err_o, m1_err_o;
  logic        ram_en_o, ram_we_o;
  logic [14:0] ram_addr_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;

  logic [31:0] mem [8192];

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  sp_ram_port_arb dut (
    .clk         (clk),
    .rstn_i      (rstn_i),
    .m0_req_i    (m0_req_i),
    .m0_addr_i   (m0_addr_i),
    .m0_we_i     (m0_we_i),
    .m0_be_i     (m0_be_i),
    .m0_wdata_i  (m0_wdata_i),
    .m0_gnt_o    (m0_gnt_o),
    .m0_rvalid_o (m0_rvalid_o),
    .m0_rdata_o  (m0_rdata_o),
    .m0_err_o    (m0_err_o),
    .m1_req_i    (m1_req_i),
    .m1_addr_i   (m1_addr_i),
    .m1_we_i     (m1_we_i),
    .m1_be_i     (m1_be_i),
    .m1_wdata_i  (m1_wdata_i),
    .m1_gnt_o    (m1_gnt_o),
    .m1_rvalid_o (m1_rvalid_o),
    .m1_rdata_o  (m1_rdata_o),
    .m1_err_o    (m1_err_o),
    .ram_en_o    (ram_en_o),
    .ram_addr_o  (ram_addr_o),
    .ram_we_o    (ram_we_o),
    .ram_be_o    (ram_be_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i)
  );

  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_be_o[b]) mem[ram_addr_o[14:2]][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
        end
      end else begin
        ram_rdata_i <= mem[ram_addr_o[14:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drv0(input logic rq, input logic [31:0] a, input logic w,
                      input logic [3:0] be, input logic [31:0] wd);
    m0_req_i = rq; m0_addr_i = a; m0_we_i = w; m0_be_i = be; m0_wdata_i = wd;
  endtask

  task automatic drv1(input logic rq, input logic [31:0] a, input logic w,
                      input logic [3:0] be, input logic [31:0] wd);
    m1_req_i = rq; m1_addr_i = a; m1_we_i = w; m1_be_i = be; m1_wdata_i = wd;
  endtask

  task automatic idle();
    drv0(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    drv1(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    idle();
    tick();
    tick();
    rstn_i = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
    mem[32'h100 >> 2] = 32'hDEADBEEF;
    mem[32'h104 >> 2] = 32'h11112222;
    mem[32'h040 >> 2] = 32'h12345678;
    ram_rdata_i = 32'h0;
    rstn_i = 1'b0;
    idle();
    @(negedge clk);
    #1;
    chk("rst_gnt0", 32'(m0_gnt_o), 32'h0);
    chk("rst_gnt1", 32'(m1_gnt_o), 32'h0);
    chk("rst_rv0", 32'(m0_rvalid_o), 32'h0);
    chk("rst_rv1", 32'(m1_rvalid_o), 32'h0);
    chk("rst_ram_en", 32'(ram_en_o), 32'h0);
    chk("rst_rdata0", m0_rdata_o, 32'h0);
    tick();
    rstn_i = 1'b1;
    tick();

    // single read from M0
    drv0(1'b1, 32'h100, 1'b0, 4'hF, 32'h0);
    #1;
    chk("rd_gnt0", 32'(m0_gnt_o), 32'h1);
    chk("rd_gnt1", 32'(m1_gnt_o), 32'h0);
    chk("rd_ram_en", 32'(ram_en_o), 32'h1);
    chk("rd_ram_addr", 32'(ram_addr_o), 32'h100);
    tick();
    idle();
    chk("rd_rv0", 32'(m0_rvalid_o), 32'h1);
    chk("rd_rdata0", m0_rdata_o, 32'hDEADBEEF);
    chk("rd_err0", 32'(m0_err_o), 32'h0);
    chk("rd_rv1", 32'(m1_rvalid_o), 32'h0);
    tick();
    chk("rd_rv0_done", 32'(m0_rvalid_o), 32'h0);

    // contention: alternate grants starting at M0
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drv0(1'b1, 32'h100, 1'b0, 4'hF, 32'h0);
      drv1(1'b1, 32'h104, 1'b0, 4'hF, 32'h0);
      #1;
      chk($sformatf("rr_gnt0_%0d", i), 32'(m0_gnt_o), 32'((i % 2) == 0));
      chk($sformatf("rr_gnt1_%0d", i), 32'(m1_gnt_o), 32'((i % 2) == 1));
      if (i > 0) begin
        chk($sformatf("rr_rv0_%0d", i), 32'(m0_rvalid_o), 32'((i % 2) == 1));
        chk($sformatf("rr_rv1_%0d", i), 32'(m1_rvalid_o), 32'((i % 2) == 0));
        chk($sformatf("rr_rd_%0d", i), (i % 2) ? m0_rdata_o : m1_rdata_o,
            (i % 2) ? 32'hDEADBEEF : 32'h11112222);
      end
      tick();
    end
    idle();
    chk("rr_rv1_last", 32'(m1_rvalid_o), 32'h1);
    chk("rr_rd1_last", m1_rdata_o, 32'h11112222);
    chk("rr_rv0_last", 32'(m0_rvalid_o), 32'h0);
    tick();

    // partial write then read-back from M1
    drv1(1'b1, 32'h40, 1'b1, 4'b0011, 32'hA5A5A5A5);
    #1;
    chk("wr_gnt1", 32'(m1_gnt_o), 32'h1);
    chk("wr_ram_we", 32'(ram_we_o), 32'h1);
    chk("wr_ram_be", 32'(ram_be_o), 32'h3);
    tick();
    drv1(1'b1, 32'h40, 1'b0, 4'hF, 32'h0);
    chk("wr_rv1", 32'(m1_rvalid_o), 32'h1);
    chk("wr_err1", 32'(m1_err_o), 32'h0);
    #1;
    chk("rb_gnt1", 32'(m1_gnt_o), 32'h1);
    chk("rb_ram_we", 32'(ram_we_o), 32'h0);
    tick();
    idle();
    chk("rb_rv1", 32'(m1_rvalid_o), 32'h1);
    chk("rb_rdata1", m1_rdata_o, 32'h1234A5A5);
    tick();

    // out-of-range read
    drv0(1'b1, 32'h0000_8000, 1'b0, 4'hF, 32'h0);
    #1;
    chk("oor_gnt0", 32'(m0_gnt_o), 32'h1);
    chk("oor_ram_en", 32'(ram_en_o), 32'h0);
    chk("oor_ram_we", 32'(ram_we_o), 32'h0);
    tick();
    idle();
    chk("oor_rv0", 32'(m0_rvalid_o), 32'h1);
    chk("oor_err0", 32'(m0_err_o), 32'h1);
    chk("oor_rdata0", m0_rdata_o, 32'h0);
    tick();
    chk("oor_err0_clr", 32'(m0_err_o), 32'h0);

    // reset right after a grant drops the response
    drv0(1'b1, 32'h100, 1'b0, 4'hF, 32'h0);
    #1;
    chk("mr_gnt0", 32'(m0_gnt_o), 32'h1);
    tick();
    idle();
    rstn_i = 1'b0;
    #1;
    chk("mr_rv0_in_rst", 32'(m0_rvalid_o), 32'h0);
    tick();
    rstn_i = 1'b1;
    chk("mr_rv0_rel", 32'(m0_rvalid_o), 32'h0);
    tick();
    chk("mr_rv0_after", 32'(m0_rvalid_o), 32'h0);
    chk("mr_rv1_after", 32'(m1_rvalid_o), 32'h0);
    drv0(1'b1, 32'h100, 1'b0, 4'hF, 32'h0);
    drv1(1'b1, 32'h104, 1'b0, 4'hF, 32'h0);
    #1;
    chk("mr_gnt0_first", 32'(m0_gnt_o), 32'h1);
    chk("mr_gnt1_first", 32'(m1_gnt_o), 32'h0);
    tick();

    // M0 withdraws before being granted; pointer now favours M1
    chk("wd_gnt1_a", 32'(m1_gnt_o), 32'h1);
    chk("wd_gnt0_a", 32'(m0_gnt_o), 32'h0);
    tick();
    drv0(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    #1;
    chk("wd_gnt1_b", 32'(m1_gnt_o), 32'h1);
    chk("wd_rv1_b", 32'(m1_rvalid_o), 32'h1);
    chk("wd_rv0_b", 32'(m0_rvalid_o), 32'h0);
    tick();
    idle();
    chk("wd_rv1_c", 32'(m1_rvalid_o), 32'h1);
    chk("wd_rv0_c", 32'(m0_rvalid_o), 32'h0);
    tick();
    chk("wd_rv0_d", 32'(m0_rvalid_o), 32'h0);
    chk("wd_rv1_d", 32'(m1_rvalid_o), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
